dunc16_memif: RTL and testbench
===============================

DUNC16_MEMIF -- requirements
Module: dunc16_memif

Interface
REQ-001 SHALL have parameter ADDR_W, default 12, number of implemented word-address bits (4096 x 16 words).
REQ-002 SHALL have parameter WAIT_STATES, default 1, extra cycles inserted before each access completes (legal 0..7).
REQ-003 SHALL have port CLK  input  1  system clock; all state updates on rising edge.
REQ-004 SHALL have port RESET  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port MA_OUT  input  16  word address from the CPU MA register.
REQ-006 SHALL have port MD_OUT  input  16  write data from the CPU MD register.
REQ-007 SHALL have port RD_REQ  input  1  single-cycle read request strobe.
REQ-008 SHALL have port WR_REQ  input  1  single-cycle write request strobe (asserted from DO_WRITE).
REQ-009 SHALL have port MEMORY_READ  output  16  read data to the CPU MD input, held until the next completed read.
REQ-010 SHALL have port MEM_READY  output  1  one-cycle pulse marking access completion.
REQ-011 SHALL have port MEM_BUSY  output  1  high while an access is in progress.
REQ-012 SHALL have port MEM_ERR  output  1  one-cycle pulse flagging a rejected request.

Function
REQ-013 SHALL implement FSM states IDLE, WAIT, ACCESS, DONE.
REQ-014 SHALL, in IDLE with exactly one of RD_REQ/WR_REQ high, latch MA_OUT[ADDR_W-1:0], MD_OUT and the direction, then enter WAIT (WAIT_STATES>0) or ACCESS (WAIT_STATES=0).
REQ-015 SHALL count WAIT_STATES cycles in WAIT with a 3-bit counter, then enter ACCESS.
REQ-016 SHALL, in ACCESS, perform one RAM read or write at the latched address, then enter DONE.
REQ-017 SHALL, in DONE, pulse MEM_READY for one cycle, update MEMORY_READ (reads only), and return to IDLE.
REQ-018 SHALL give latency: request sampled at edge k -> MEM_READY high in cycle after edge k+2+WAIT_STATES.
REQ-019 SHALL drive MEM_BUSY high in WAIT, ACCESS and DONE, low in IDLE.
REQ-020 SHALL ignore MA_OUT[15:ADDR_W]; addresses wrap modulo 2**ADDR_W.
REQ-021 SHALL, with RD_REQ and WR_REQ both high in IDLE, perform no access, stay IDLE and pulse MEM_ERR next cycle.
REQ-022 SHALL, on any request while MEM_BUSY, ignore it, leave the current access unaffected and pulse MEM_ERR next cycle.
REQ-023 SHALL leave MEMORY_READ unchanged on writes and on rejected requests.
REQ-024 SHALL accept a new request in the same cycle MEM_BUSY returns low (back-to-back, no gap beyond IDLE).

Reset
REQ-025 SHALL, on RESET low, force state IDLE, wait counter 0, MEMORY_READ 16'h0000, MEM_READY 0, MEM_BUSY 0, MEM_ERR 0, asynchronously.
REQ-026 SHALL, on reset during WAIT/ACCESS/DONE, abort the access with no MEM_READY; a write not yet in ACCESS SHALL NOT modify RAM.
REQ-027 SHALL NOT clear RAM contents on reset.

Structure
REQ-028 SHALL take the FSM state enum, default ADDR_W and WAIT_STATES values from shared package dunc16_pkg.
REQ-029 SHALL instantiate one sub-module dunc16_ram: synchronous single-port 2**ADDR_W x 16, write-enable, registered read, no reset.

Verification
REQ-030 SHALL check: WR_REQ, MA=16'h0010, MD=16'hBEEF, then RD_REQ at 16'h0010 -> MEMORY_READ=16'hBEEF with MEM_READY 3 cycles after request (WAIT_STATES=1).
REQ-031 SHALL check: write 16'h1234 to 16'hF005, read 16'h0005 -> 16'h1234 (wrap).
REQ-032 SHALL check: RD_REQ and WR_REQ together -> MEM_ERR one cycle, MEM_BUSY stays 0, RAM unchanged.
REQ-033 SHALL check: RD_REQ while busy reading 16'h0020 -> MEM_ERR pulse, original read completes with correct data, one MEM_READY only.
REQ-034 SHALL check: RESET low during WAIT of write 16'hAAAA to 16'h0030 -> all outputs 0, later read of 16'h0030 returns prior value.
REQ-035 SHALL check: WAIT_STATES=0, ten back-to-back reads -> MEM_READY every 3 cycles, data matching preloaded pattern.

Source files
------------

// File: rtl/dunc16_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dunc16_pkg
// Purpose  : Shared definitions for the DUNC16 memory interface: controller
//            state encoding and default geometry/timing parameters.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package dunc16_pkg;

    localparam int DEFAULT_ADDR_W      = 12;
    localparam int DEFAULT_WAIT_STATES = 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        ACCESS = 2'd2,
        DONE   = 2'd3
    } memif_state_t;

endpackage : dunc16_pkg
`default_nettype wire

// File: rtl/dunc16_ram.sv
`default_nettype none
// ============================================================================
// Module   : dunc16_ram
// Purpose  : Synchronous single-port 2**ADDR_W x 16 RAM with write enable and
//            registered read data. Contents are never reset.
// Ports    : CLK   - clock, rising edge
//            en    - access enable for this cycle
//            we    - write when en is high, otherwise read
//            addr  - word address
//            wdata - write data
//            rdata - read data, valid the cycle after a read access
// Revision : 1.0 - initial release
// ============================================================================
module dunc16_ram
    import dunc16_pkg::*;
#(
    parameter int ADDR_W = DEFAULT_ADDR_W
) (
    input  logic              CLK,
    input  logic              en,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [15:0]       wdata,
    output logic [15:0]       rdata
);

    logic [15:0] mem [2**ADDR_W];

    always_ff @(posedge CLK) begin
        if (en) begin
            if (we) begin
                mem[addr] <= wdata;
            end else begin
                rdata <= mem[addr];
            end
        end
    end

endmodule : dunc16_ram
`default_nettype wire

// File: rtl/dunc16_memif.sv
`default_nettype none
// ============================================================================
// Module   : dunc16_memif
// Purpose  : Bridges the DUNC16 CPU MA/MD registers to an on-chip RAM.
//            Each accepted request walks IDLE -> (WAIT) -> ACCESS -> DONE and
//            ends with a one-cycle MEM_READY pulse. Requests that arrive while
//            busy, or read+write together, are dropped and flagged on MEM_ERR.
// Ports    : CLK         - system clock, rising edge
//            RESET       - asynchronous active-low reset
//            MA_OUT      - word address (upper bits beyond ADDR_W ignored)
//            MD_OUT      - write data
//            RD_REQ      - single-cycle read strobe
//            WR_REQ      - single-cycle write strobe
//            MEMORY_READ - last completed read data
//            MEM_READY   - one-cycle completion pulse
//            MEM_BUSY    - access in progress
//            MEM_ERR     - one-cycle rejected-request pulse
// Revision : 1.0 - initial release
// ============================================================================
module dunc16_memif
    import dunc16_pkg::*;
#(
    parameter int ADDR_W      = DEFAULT_ADDR_W,
    parameter int WAIT_STATES = DEFAULT_WAIT_STATES
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [15:0] MA_OUT,
    input  logic [15:0] MD_OUT,
    input  logic        RD_REQ,
    input  logic        WR_REQ,
    output logic [15:0] MEMORY_READ,
    output logic        MEM_READY,
    output logic        MEM_BUSY,
    output logic        MEM_ERR
);

    // Final count value in WAIT; irrelevant when WAIT is never entered.
    localparam logic [2:0] WAIT_LAST = 3'((WAIT_STATES == 0) ? 0 : WAIT_STATES - 1);

    memif_state_t      state;
    memif_state_t      next_state;
    logic [2:0]        wait_cnt;
    logic [ADDR_W-1:0] addr_q;
    logic [15:0]       wdata_q;
    logic              is_write;
    logic              accept;
    logic              err_next;
    logic [15:0]       ram_rdata;
    logic              unused_ma;

    // Address bits above ADDR_W are deliberately dropped (modulo wrap).
    assign unused_ma = ^(MA_OUT >> ADDR_W);

    assign MEM_BUSY = (state != IDLE);

    always_comb begin
        next_state = state;
        accept     = 1'b0;
        err_next   = 1'b0;
        case (state)
            IDLE: begin
                accept   = RD_REQ ^ WR_REQ;
                err_next = RD_REQ & WR_REQ;
                if (accept) begin
                    next_state = (WAIT_STATES == 0) ? ACCESS : WAIT;
                end
            end
            WAIT: begin
                err_next = RD_REQ | WR_REQ;
                if (wait_cnt == WAIT_LAST) begin
                    next_state = ACCESS;
                end
            end
            ACCESS: begin
                err_next   = RD_REQ | WR_REQ;
                next_state = DONE;
            end
            DONE: begin
                err_next   = RD_REQ | WR_REQ;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state       <= IDLE;
            wait_cnt    <= 3'd0;
            addr_q      <= '0;
            wdata_q     <= 16'h0000;
            is_write    <= 1'b0;
            MEMORY_READ <= 16'h0000;
            MEM_READY   <= 1'b0;
            MEM_ERR     <= 1'b0;
        end else begin
            state     <= next_state;
            MEM_ERR   <= err_next;
            MEM_READY <= (state == DONE);
            wait_cnt  <= (state == WAIT) ? wait_cnt + 3'd1 : 3'd0;
            if (accept) begin
                addr_q   <= MA_OUT[ADDR_W-1:0];
                wdata_q  <= MD_OUT;
                is_write <= WR_REQ;
            end
            // RAM read data was registered on the edge that left ACCESS.
            if (state == DONE && !is_write) begin
                MEMORY_READ <= ram_rdata;
            end
        end
    end

    dunc16_ram #(
        .ADDR_W (ADDR_W)
    ) u_ram (
        .CLK   (CLK),
        .en    (state == ACCESS),
        .we    (is_write),
        .addr  (addr_q),
        .wdata (wdata_q),
        .rdata (ram_rdata)
    );

endmodule : dunc16_memif
`default_nettype wire

// File: tb/tb_dunc16_memif.sv
`default_nettype none
// ============================================================================
// Module   : tb_dunc16_memif
// Purpose  : Self-checking bench for dunc16_memif. Two instances share clock
//            and reset: index 0 uses WAIT_STATES=1, index 1 WAIT_STATES=0.
//            Expected data and timing come from a word-array memory model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dunc16_memif;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic [15:0] ma   [2];
    logic [15:0] md   [2];
    logic        rd   [2];
    logic        wr   [2];
    logic [15:0] mr   [2];
    logic        rdy  [2];
    logic        busy [2];
    logic        err  [2];

    int checks = 0;
    int errors = 0;

    // Reference model: plain word memory per instance plus last read value.
    logic [15:0] model_mem [2][4096];
    logic [15:0] model_rd  [2];
    int          ws        [2];

    always #5 CLK = ~CLK;

    dunc16_memif #(.ADDR_W(12), .WAIT_STATES(1)) u_dut_ws1 (
        .CLK(CLK), .RESET(RESET), .MA_OUT(ma[0]), .MD_OUT(md[0]),
        .RD_REQ(rd[0]), .WR_REQ(wr[0]), .MEMORY_READ(mr[0]),
        .MEM_READY(rdy[0]), .MEM_BUSY(busy[0]), .MEM_ERR(err[0])
    );

    dunc16_memif #(.ADDR_W(12), .WAIT_STATES(0)) u_dut_ws0 (
        .CLK(CLK), .RESET(RESET), .MA_OUT(ma[1]), .MD_OUT(md[1]),
        .RD_REQ(rd[1]), .WR_REQ(wr[1]), .MEMORY_READ(mr[1]),
        .MEM_READY(rdy[1]), .MEM_BUSY(busy[1]), .MEM_ERR(err[1])
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle_outputs(input int s, input string tag);
        check($sformatf("%s_mr%0d", tag, s),   32'(mr[s]),   32'(model_rd[s]));
        check($sformatf("%s_rdy%0d", tag, s),  32'(rdy[s]),  32'd0);
        check($sformatf("%s_busy%0d", tag, s), 32'(busy[s]), 32'd0);
        check($sformatf("%s_err%0d", tag, s),  32'(err[s]),  32'd0);
    endtask

    // Called at a negedge with instance s idle. Returns at the negedge of the
    // cycle in which MEM_READY is seen, so a follow-up call is back-to-back.
    task automatic access(input int s, input bit is_wr, input logic [15:0] a,
                          input logic [15:0] d, output time t_ready);
        int n;
        ma[s] = a;
        md[s] = d;
        rd[s] = !is_wr;
        wr[s] = is_wr;
        @(negedge CLK);
        rd[s] = 1'b0;
        wr[s] = 1'b0;
        check($sformatf("busy_after_req%0d", s), 32'(busy[s]), 32'd1);
        n = 0;
        while (!rdy[s] && n < 20) begin
            @(negedge CLK);
            n++;
        end
        t_ready = $time;
        check($sformatf("latency%0d", s), 32'(n), 32'(2 + ws[s]));
        if (is_wr) model_mem[s][a % 4096] = d;
        else       model_rd[s] = model_mem[s][a % 4096];
        check($sformatf("mem_read%0d@%0h", s, a), 32'(mr[s]), 32'(model_rd[s]));
        check($sformatf("busy_at_ready%0d", s), 32'(busy[s]), 32'd0);
    endtask

    initial begin
        time t, t_prev;
        int  n_rdy, n_err, rdy_cyc;
        logic [15:0] cap;
        logic [11:0] wq [$];

        ws[0] = 1;
        ws[1] = 0;
        for (int s = 0; s < 2; s++) begin
            ma[s] = 16'h0; md[s] = 16'h0; rd[s] = 1'b0; wr[s] = 1'b0;
            model_rd[s] = 16'h0000;
        end

        // Reset state
        #2 RESET = 1'b0;
        @(negedge CLK);
        check_idle_outputs(0, "reset");
        check_idle_outputs(1, "reset");
        RESET = 1'b1;
        @(negedge CLK);

        // Basic write then read, WAIT_STATES=1 (latency 3 checked inside)
        access(0, 1'b1, 16'h0010, 16'hBEEF, t);
        access(0, 1'b0, 16'h0010, 16'h0000, t);
        check("beef_read", 32'(mr[0]), 32'h0000BEEF);

        // Address wrap on upper bits
        access(0, 1'b1, 16'hF005, 16'h1234, t);
        access(0, 1'b0, 16'h0005, 16'h0000, t);
        check("wrap_read", 32'(mr[0]), 32'h00001234);

        // Simultaneous read+write in IDLE
        access(0, 1'b1, 16'h0040, 16'h5A5A, t);
        @(negedge CLK);
        ma[0] = 16'h0040; md[0] = 16'hFFFF; rd[0] = 1'b1; wr[0] = 1'b1;
        @(negedge CLK);
        rd[0] = 1'b0; wr[0] = 1'b0;
        check("both_err", 32'(err[0]), 32'd1);
        check("both_busy", 32'(busy[0]), 32'd0);
        @(negedge CLK);
        check("both_err_clear", 32'(err[0]), 32'd0);
        check("both_busy_clear", 32'(busy[0]), 32'd0);
        access(0, 1'b0, 16'h0040, 16'h0000, t);
        check("both_ram_unchanged", 32'(mr[0]), 32'h00005A5A);

        // Read request while busy reading
        access(0, 1'b1, 16'h0020, 16'hC0DE, t);
        access(0, 1'b1, 16'h0099, 16'h7777, t);
        @(negedge CLK);
        ma[0] = 16'h0020; rd[0] = 1'b1;
        @(negedge CLK);
        ma[0] = 16'h0099;
        @(negedge CLK);
        rd[0] = 1'b0;
        check("busy_rd_err", 32'(err[0]), 32'd1);
        n_rdy = 0; n_err = 0; rdy_cyc = -1; cap = 16'h0;
        for (int c = 2; c < 10; c++) begin
            @(negedge CLK);
            if (rdy[0]) begin n_rdy++; rdy_cyc = c; cap = mr[0]; end
            if (err[0]) n_err++;
        end
        model_rd[0] = model_mem[0][12'h020];
        check("busy_rd_ready_count", 32'(n_rdy), 32'd1);
        check("busy_rd_ready_cycle", 32'(rdy_cyc), 32'd3);
        check("busy_rd_extra_err", 32'(n_err), 32'd0);
        check("busy_rd_data", 32'(cap), 32'h0000C0DE);

        // Reset during WAIT of a write
        access(0, 1'b1, 16'h0030, 16'h1111, t);
        @(negedge CLK);
        ma[0] = 16'h0030; md[0] = 16'hAAAA; wr[0] = 1'b1;
        @(negedge CLK);
        wr[0] = 1'b0;
        check("pre_reset_busy", 32'(busy[0]), 32'd1);
        RESET = 1'b0;
        #1;
        model_rd[0] = 16'h0000;
        model_rd[1] = 16'h0000;
        check_idle_outputs(0, "midreset");
        check_idle_outputs(1, "midreset");
        @(negedge CLK);
        RESET = 1'b1;
        n_rdy = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge CLK);
            if (rdy[0]) n_rdy++;
        end
        check("aborted_no_ready", 32'(n_rdy), 32'd0);
        access(0, 1'b0, 16'h0030, 16'h0000, t);
        check("aborted_write_ram", 32'(mr[0]), 32'h00001111);

        // WAIT_STATES=0: preload then ten back-to-back reads
        @(negedge CLK);
        for (int i = 0; i < 10; i++)
            access(1, 1'b1, 16'(16'h0100 + i), 16'(16'hA500 + i * 16'h0111), t);
        t_prev = 0;
        for (int i = 0; i < 10; i++) begin
            access(1, 1'b0, 16'(16'h0100 + i), 16'h0000, t);
            check($sformatf("b2b_data%0d", i), 32'(mr[1]), 32'(16'hA500 + i * 16'h0111));
            if (i > 0) check($sformatf("b2b_period%0d", i), 32'(t - t_prev), 32'd30);
            t_prev = t;
        end

        // Randomized traffic on both instances
        for (int s = 0; s < 2; s++) begin
            wq.delete();
            @(negedge CLK);
            for (int i = 0; i < 30; i++) begin
                logic [15:0] a;
                bit          w;
                w = (wq.size() == 0) || ($urandom_range(0, 1) == 1);
                if (w) begin
                    a = 16'($urandom);
                    wq.push_back(a[11:0]);
                end else begin
                    a = {4'($urandom), wq[$urandom_range(0, wq.size() - 1)]};
                end
                access(s, w, a, 16'($urandom), t);
            end
        end

        @(negedge CLK);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_dunc16_memif
`default_nettype wire
